sar_compare_master: RTL

Successive-approximation search controller that drives the trial operand of a registered 6-bit comparator (signed/unsigned, G/S/E outputs) and consumes its results. It recovers an unknown 6-bit target value A, which is wired to the comparator's A input, by binary search. The comparator latency is a parameter. The block is the initiator side of the comparator interface: it issues B and s, and reads back G/S/E.

---
 rtl/sar_compare_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sar_compare_master.sv
// rtl/sar_compare_master.sv - SAR search controller for a registered 6-bit comparator; optional macro SAR_EARLY_EXIT_EN
module sar_compare_master #(
  parameter int CMP_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode_s,
  input  logic       cmp_g,
  input  logic       cmp_s,
  input  logic       cmp_e,
  output logic [5:0] trial,
  output logic       s_out,
  output logic       busy,
  output logic       done,
  output logic [5:0] result,
  output logic       exact,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(CMP_LATENCY);

  state_t     state_q, state_d;
  logic [5:0] u_q, u_d;
  logic [2:0] k_q, k_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       mode_q, mode_d;
  logic [5:0] trial_q, trial_d;
  logic [5:0] result_q, result_d;
  logic       exact_q, exact_d;
  logic       err_q, err_d;

  // Flipping the MSB turns the offset-binary search register into a two's-complement trial.
  function automatic logic [5:0] map_trial(input logic [5:0] u, input logic m);
    return m ? (u ^ 6'b100000) : u;
  endfunction

  // State and datapath registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      u_q      <= 6'd0;
      k_q      <= 3'd0;
      wcnt_q   <= 3'd0;
      mode_q   <= 1'b0;
      trial_q  <= 6'd0;
      result_q <= 6'd0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      k_q      <= k_d;
      wcnt_q   <= wcnt_d;
      mode_q   <= mode_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: wait out the comparator latency, then decide one bit per evaluation.
  always_comb begin
    logic [5:0] u_nxt;
    logic [2:0] k_m1;
    logic       one_hot;

    state_d  = state_q;
    u_d      = u_q;
    k_d      = k_q;
    wcnt_d   = wcnt_q;
    mode_d   = mode_q;
    trial_d  = trial_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;
    u_nxt    = u_q;
    k_m1     = k_q - 3'd1;
    one_hot  = ({cmp_g, cmp_s, cmp_e} == 3'b100) ||
               ({cmp_g, cmp_s, cmp_e} == 3'b010) ||
               ({cmp_g, cmp_s, cmp_e} == 3'b001);

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_s;
          u_d     = 6'b100000;
          k_d     = 3'd5;
          wcnt_d  = LAT;
          trial_d = map_trial(6'b100000, mode_s);
          exact_d = 1'b0;
          err_d   = 1'b0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else if (!one_hot) begin
          err_d    = 1'b1;
          result_d = trial_q;
          state_d  = DONE;
`ifdef SAR_EARLY_EXIT_EN
        end else if (cmp_e) begin
          exact_d  = 1'b1;
          result_d = trial_q;
          state_d  = DONE;
`endif
        end else begin
          // Without early exit an equal result keeps the bit, just like greater.
          if (cmp_e) exact_d = 1'b1;
          if (cmp_s) u_nxt[k_q] = 1'b0;
          if (k_q == 3'd0) begin
            u_d      = u_nxt;
            result_d = map_trial(u_nxt, mode_q);
            state_d  = DONE;
          end else begin
            u_nxt[k_m1] = 1'b1;
            u_d         = u_nxt;
            k_d         = k_m1;
            wcnt_d      = LAT;
            trial_d     = map_trial(u_nxt, mode_q);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign trial  = trial_q;
  assign s_out  = mode_q;
  assign busy   = (state_q == WAIT);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign exact  = exact_q;
  assign err    = err_q;

endmodule
